// File: rtl/tdc_readout_pkg.sv
// Shared types and frame constants for the TDC readout sequencer.
package tdc_readout_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SETTLE,
        SAMPLE,
        EMIT,
        DONE
    } state_t;

    localparam logic [1:0] CH_SENSOR = 2'd0;
    localparam logic [1:0] CH_TDC    = 2'd1;
    localparam logic [1:0] CH_RO     = 2'd2;
    localparam logic [1:0] CH_RO2    = 2'd3;

    localparam logic [7:0] FRAME_HDR = 8'hA5;
    localparam int         FRAME_LEN = 6;

endpackage

// File: rtl/tdc_readout_sequencer_popcount8.sv
// Combinational 8-bit population count; tolerant of bubbles in the TDC code.
module popcount8 (
    input  logic [7:0] d_i,
    output logic [3:0] cnt_o
);

    always_comb begin
        cnt_o = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt_o = cnt_o + 4'(d_i[i]);
        end
    end

endmodule

// File: rtl/tdc_readout_sequencer.sv
// Steps the container's source select, samples the synchronised mux bus,
// accumulates the TDC popcount and streams a 6-byte checksummed frame.
module tdc_readout_sequencer
    import tdc_readout_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int ACC_LOG2      = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [1:0] sel_o,
    input  logic [7:0] mux_data_i,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [7:0] WAIT_LAST = 8'(SETTLE_CYCLES + SYNC_STAGES - 1);
    localparam logic [4:0] ACC_LAST  = 5'((1 << ACC_LOG2) - 1);

    logic [SYNC_STAGES-1:0][7:0] sync_q;
    logic [7:0] samp;
    logic [3:0] pop;

    state_t     state_q, state_d;
    logic [1:0] ch_q, ch_d;
    logic [1:0] sel_q, sel_d;
    logic [7:0] wait_q, wait_d;
    logic [4:0] acc_q, acc_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] slot0_q, slot0_d;
    logic [7:0] slot2_q, slot2_d;
    logic [7:0] slot3_q, slot3_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] chk_q, chk_d;
    logic [7:0] odata_q, odata_d;
    logic       ovalid_q, ovalid_d;
    logic [7:0] nxt_byte;
    logic       last_smp;

    // mux_data_i is asynchronous to clk; sample only the last flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], mux_data_i};
        end
    end

    assign samp = sync_q[SYNC_STAGES-1];

    popcount8 u_pop (
        .d_i   (samp),
        .cnt_o (pop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ch_q     <= CH_SENSOR;
            sel_q    <= CH_SENSOR;
            wait_q   <= '0;
            acc_q    <= '0;
            sum_q    <= '0;
            slot0_q  <= '0;
            slot2_q  <= '0;
            slot3_q  <= '0;
            idx_q    <= '0;
            chk_q    <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            sel_q    <= sel_d;
            wait_q   <= wait_d;
            acc_q    <= acc_d;
            sum_q    <= sum_d;
            slot0_q  <= slot0_d;
            slot2_q  <= slot2_d;
            slot3_q  <= slot3_d;
            idx_q    <= idx_d;
            chk_q    <= chk_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
        end
    end

    // Byte that follows the one currently presented; the last is the running XOR
    always_comb begin
        nxt_byte = chk_q;
        unique case (idx_q)
            3'd0:    nxt_byte = slot0_q;
            3'd1:    nxt_byte = sum_q;
            3'd2:    nxt_byte = slot2_q;
            3'd3:    nxt_byte = slot3_q;
            default: nxt_byte = chk_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        sel_d    = sel_q;
        wait_d   = wait_q;
        acc_d    = acc_q;
        sum_d    = sum_q;
        slot0_d  = slot0_q;
        slot2_d  = slot2_q;
        slot3_d  = slot3_q;
        idx_d    = idx_q;
        chk_d    = chk_q;
        odata_d  = odata_q;
        ovalid_d = ovalid_q;
        last_smp = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ch_d    = CH_SENSOR;
                    sel_d   = CH_SENSOR;
                    wait_d  = '0;
                    sum_d   = '0;
                    chk_d   = '0;
                    idx_d   = '0;
                    state_d = SETTLE;
                end
            end
            SELECT: begin
                sel_d   = ch_q;
                wait_d  = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (wait_q == WAIT_LAST) begin
                    acc_d   = '0;
                    state_d = SAMPLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            SAMPLE: begin
                if (ch_q == CH_TDC) begin
                    sum_d    = sum_q + 8'(pop);
                    acc_d    = acc_q + 5'd1;
                    last_smp = (acc_q == ACC_LAST);
                end else if (ch_q == CH_SENSOR) begin
                    slot0_d = samp;
                end else if (ch_q == CH_RO) begin
                    slot2_d = samp;
                end else begin
                    slot3_d = samp;
                end
                // Header goes out only once every slot is captured
                if (last_smp) begin
                    if (ch_q == CH_RO2) begin
                        odata_d  = FRAME_HDR;
                        ovalid_d = 1'b1;
                        idx_d    = '0;
                        chk_d    = FRAME_HDR;
                        state_d  = EMIT;
                    end else begin
                        ch_d    = ch_q + 2'd1;
                        state_d = SELECT;
                    end
                end
            end
            EMIT: begin
                if (ovalid_q && out_ready) begin
                    if (idx_q == 3'(FRAME_LEN - 1)) begin
                        ovalid_d = 1'b0;
                        odata_d  = '0;
                        state_d  = DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        odata_d = nxt_byte;
                        chk_d   = chk_q ^ nxt_byte;
                    end
                end
            end
            DONE: begin
                sel_d   = CH_SENSOR;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel_o      = sel_q;
    assign out_data   = odata_q;
    assign out_valid  = ovalid_q;
    assign busy       = (state_q != IDLE) && (state_q != DONE);
    assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_tdc_readout_sequencer.sv
// Scoreboard bench: directed frames pushed as expected bytes, monitors pop on handshakes.
module tb_tdc_readout_sequencer;

    localparam int SETTLE = 4;
    localparam int SYNC   = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] sel_o;
    logic [7:0] mux_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       busy;
    logic       frame_done;
    logic [7:0] vals [4];

    logic       start_b = 1'b0;
    logic [1:0] sel_b;
    logic [7:0] mux_b;
    logic [7:0] data_b;
    logic       valid_b;
    logic       ready_b = 1'b1;
    logic       busy_b;
    logic       done_b;
    logic [7:0] vals_b [4];

    int errors = 0;
    int checks = 0;
    int hs_cnt = 0;
    int fd_cnt = 0;
    int cyc    = 0;

    logic [7:0] expq [$];
    logic [7:0] expq_b [$];
    logic [1:0] sel_log [$];
    int         sel_t [$];
    logic [1:0] sel_prev = 2'd0;
    logic       stall_pend = 1'b0;
    logic [7:0] stall_data = 8'd0;

    always #5 clk = ~clk;

    assign mux_data = vals[sel_o];
    assign mux_b    = vals_b[sel_b];

    tdc_readout_sequencer #(.SETTLE_CYCLES(SETTLE), .ACC_LOG2(4), .SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .sel_o      (sel_o),
        .mux_data_i (mux_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    tdc_readout_sequencer #(.SETTLE_CYCLES(SETTLE), .ACC_LOG2(0), .SYNC_STAGES(SYNC)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_b),
        .sel_o      (sel_b),
        .mux_data_i (mux_b),
        .out_data   (data_b),
        .out_valid  (valid_b),
        .out_ready  (ready_b),
        .busy       (busy_b),
        .frame_done (done_b)
    );

    // Monitor for the main instance: byte order, and hold-while-stalled
    always @(negedge clk) begin
        logic [7:0] e;
        cyc++;
        if (frame_done) fd_cnt++;
        if (sel_o != sel_prev) begin
            sel_log.push_back(sel_o);
            sel_t.push_back(cyc);
            sel_prev = sel_o;
        end
        if (stall_pend && rst_n) begin
            checks++;
            if (!out_valid || out_data != stall_data) begin
                errors++;
                $display("FAIL stall_hold: valid=%0b data=%02h, required valid=1 data=%02h",
                         out_valid, out_data, stall_data);
            end
        end
        stall_pend = out_valid && !out_ready && rst_n;
        stall_data = out_data;
        if (out_valid && out_ready) begin
            hs_cnt++;
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL extra_byte: got %02h, required no byte", out_data);
            end else begin
                e = expq.pop_front();
                if (out_data != e) begin
                    errors++;
                    $display("FAIL frame_byte: got %02h, required %02h", out_data, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (valid_b && ready_b) begin
            checks++;
            if (expq_b.size() == 0) begin
                errors++;
                $display("FAIL extra_byte_b: got %02h, required no byte", data_b);
            end else begin
                e = expq_b.pop_front();
                if (data_b != e) begin
                    errors++;
                    $display("FAIL frame_byte_b: got %02h, required %02h", data_b, e);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic push_frame(input logic [7:0] s0, input logic [7:0] t, input logic [7:0] s2,
                              input logic [7:0] s3, input logic [7:0] c);
        expq.push_back(8'hA5);
        expq.push_back(s0);
        expq.push_back(t);
        expq.push_back(s2);
        expq.push_back(s3);
        expq.push_back(c);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int maxc);
        int n = 0;
        while (!frame_done && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!frame_done) begin
            errors++;
            $display("FAIL %s_timeout: frame_done=0 after %0d cycles, required 1", nm, maxc);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        vals   = '{8'h00, 8'h00, 8'h00, 8'h00};
        vals_b = '{8'h00, 8'h00, 8'h00, 8'h00};
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_sel", 32'(sel_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Test 1: basic frame, select sequence and settle spacing
        vals = '{8'h3C, 8'h0F, 8'h81, 8'h00};
        push_frame(8'h3C, 8'h40, 8'h81, 8'h00, 8'h58);
        sel_log.delete();
        sel_t.delete();
        fd_cnt = 0;
        pulse_start();
        check("t1_busy_after_start", 32'(busy), 32'd1);
        wait_done("t1", 400);
        repeat (3) @(posedge clk);
        #1;
        check("t1_done_pulses", 32'(fd_cnt), 32'd1);
        check("t1_busy_low", 32'(busy), 32'd0);
        check("t1_queue_empty", 32'(expq.size()), 32'd0);
        check("t1_sel_changes", 32'(sel_log.size()), 32'd4);
        if (sel_log.size() == 4) begin
            check("t1_sel_a", 32'(sel_log[0]), 32'd1);
            check("t1_sel_b", 32'(sel_log[1]), 32'd2);
            check("t1_sel_c", 32'(sel_log[2]), 32'd3);
            check("t1_sel_d", 32'(sel_log[3]), 32'd0);
            check("t1_space_tdc", 32'(sel_t[1] - sel_t[0]), 32'(SETTLE + SYNC + 16 + 1));
            check("t1_space_ro", 32'(sel_t[2] - sel_t[1]), 32'(SETTLE + SYNC + 1 + 1));
        end

        // Test 2: saturated TDC code
        vals = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        push_frame(8'hFF, 8'h80, 8'hFF, 8'hFF, 8'hDA);
        pulse_start();
        wait_done("t2", 400);
        check("t2_queue_empty", 32'(expq.size()), 32'd0);

        // Test 3: bubble code, single-sample accumulation
        vals_b = '{8'h11, 8'h5A, 8'h22, 8'h33};
        expq_b.push_back(8'hA5);
        expq_b.push_back(8'h11);
        expq_b.push_back(8'h04);
        expq_b.push_back(8'h22);
        expq_b.push_back(8'h33);
        expq_b.push_back(8'hA1);
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("t3_done_seen", 32'(done_b), 32'd1);
        @(posedge clk); #1;
        check("t3_queue_empty", 32'(expq_b.size()), 32'd0);

        // Test 4: back-pressure 1,0,0,1
        vals = '{8'h12, 8'hF0, 8'h34, 8'h56};
        push_frame(8'h12, 8'h40, 8'h34, 8'h56, 8'h95);
        hs_cnt = 0;
        pulse_start();
        n = 0;
        while (!frame_done && n < 400) begin
            out_ready = (n % 4 == 0) || (n % 4 == 3);
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b1;
        check("t4_done_seen", 32'(frame_done), 32'd1);
        @(posedge clk); #1;
        check("t4_handshakes", 32'(hs_cnt), 32'd6);
        check("t4_queue_empty", 32'(expq.size()), 32'd0);

        // Test 5: start mid-frame and in the frame_done cycle are ignored
        vals = '{8'h01, 8'h03, 8'h07, 8'h0F};
        push_frame(8'h01, 8'h20, 8'h07, 8'h0F, 8'h8C);
        fd_cnt = 0;
        hs_cnt = 0;
        pulse_start();
        repeat (20) @(posedge clk);
        #1;
        pulse_start();
        n = 0;
        while (!frame_done && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5_done_seen", 32'(frame_done), 32'd1);
        pulse_start();
        repeat (60) @(posedge clk);
        #1;
        check("t5_done_pulses", 32'(fd_cnt), 32'd1);
        check("t5_handshakes", 32'(hs_cnt), 32'd6);
        check("t5_idle_busy", 32'(busy), 32'd0);
        check("t5_idle_valid", 32'(out_valid), 32'd0);
        vals = '{8'h3C, 8'h0F, 8'h81, 8'h00};
        push_frame(8'h3C, 8'h40, 8'h81, 8'h00, 8'h58);
        pulse_start();
        wait_done("t5_next", 400);
        check("t5_next_queue_empty", 32'(expq.size()), 32'd0);

        // Test 6: asynchronous reset while byte 3 is presented
        push_frame(8'h3C, 8'h40, 8'h81, 8'h00, 8'h58);
        hs_cnt = 0;
        out_ready = 1'b0;
        pulse_start();
        n = 0;
        while (!out_valid && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("t6_valid_seen", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("t6_byte3_present", 32'(out_data), 32'h81);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_data", 32'(out_data), 32'd0);
        check("t6_rst_sel", 32'(sel_o), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_handshakes", 32'(hs_cnt), 32'd3);
        expq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        push_frame(8'h3C, 8'h40, 8'h81, 8'h00, 8'h58);
        pulse_start();
        wait_done("t6_fresh", 400);
        check("t6_queue_empty", 32'(expq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
